// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - hazard/syscall requests in, pipeline register controls out
interface pipeline_sequencer_if;
  logic halt_req;
  logic pause_req;
  logic load_use;
  logic branch_taken;
  logic pc_en;
  logic if_id_en;
  logic id_exe_en;
  logic exe_mem_en;
  logic mem_wb_en;
  logic if_id_clr;
  logic id_exe_clr;

  modport master (
    input  halt_req, pause_req, load_use, branch_taken,
    output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_clr, id_exe_clr
  );

  modport slave (
    output halt_req, pause_req, load_use, branch_taken,
    input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_clr, id_exe_clr
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/step/pause/halt sequencer driving pipeline register enables
module pipeline_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  pipeline_sequencer_if.master ctl,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_RUN    = 3'b001;
  localparam logic [2:0] S_STEP   = 3'b010;
  localparam logic [2:0] S_PAUSED = 3'b011;
  localparam logic [2:0] S_HALTED = 3'b100;

  logic [2:0]       state_q, state_d;
  logic             run_q, run_d;
  logic             step_q, step_d;
  logic             armed_q, armed_d;
  logic             resume_q, resume_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic run_edge, step_edge, in_exec, pause_hon, active, stall_hit, flush_hit;
  logic [4:0] en;
  logic [1:0] clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    // armed_q masks the first post-reset cycle so a button held through reset is not an edge
    run_edge  = armed_q & run_btn & ~run_q;
    step_edge = armed_q & step_btn & ~step_q;
    in_exec   = (state_q == S_RUN) || (state_q == S_STEP);
    pause_hon = ctl.pause_req & ~resume_q;
    active    = ~rst & in_exec & ~ctl.halt_req & ~pause_hon;
    stall_hit = active & ctl.load_use & ~ctl.branch_taken;
    flush_hit = active & ctl.branch_taken;

    en  = 5'b00000;
    clr = 2'b00;
    if (flush_hit) begin
      en  = 5'b11111;
      clr = 2'b11;
    end else if (stall_hit) begin
      en  = 5'b00111;
      clr = 2'b01;
    end else if (active) begin
      en  = 5'b11111;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE, S_PAUSED: begin
        if (run_edge)       state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      S_RUN: begin
        if (ctl.halt_req)   state_d = S_HALTED;
        else if (pause_hon) state_d = S_PAUSED;
      end
      S_STEP: begin
        if (ctl.halt_req)   state_d = S_HALTED;
        else                state_d = S_PAUSED;
      end
      S_HALTED:             state_d = S_HALTED;
      default:              state_d = S_IDLE;
    endcase

    resume_d = (state_q == S_PAUSED) && ((state_d == S_RUN) || (state_d == S_STEP));
    run_d    = run_btn;
    step_d   = step_btn;
    armed_d  = 1'b1;
    cycle_d  = sat_inc(cycle_q, active);
    stall_d  = sat_inc(stall_q, stall_hit);
    flush_d  = sat_inc(flush_q, flush_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      armed_q  <= 1'b0;
      resume_q <= 1'b0;
      cycle_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      step_q   <= step_d;
      armed_q  <= armed_d;
      resume_q <= resume_d;
      cycle_q  <= cycle_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign ctl.pc_en      = en[4];
  assign ctl.if_id_en   = en[3];
  assign ctl.id_exe_en  = en[2];
  assign ctl.exe_mem_en = en[1];
  assign ctl.mem_wb_en  = en[0];
  assign ctl.if_id_clr  = clr[1];
  assign ctl.id_exe_clr = clr[0];
  assign state          = state_q;
  assign cycle_cnt      = cycle_q;
  assign stall_cnt      = stall_q;
  assign flush_cnt      = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed bench for pipeline_sequencer (default and 4-bit counters)
module tb_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst, run_btn, step_btn, halt_req, pause_req, load_use, branch_taken;
  int total = 0;
  int bad = 0;

  pipeline_sequencer_if ctl ();
  pipeline_sequencer_if ctl4 ();

  logic [2:0]  state, state4;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [3:0]  cycle4, stall4, flush4;

  assign ctl.halt_req      = halt_req;
  assign ctl.pause_req     = pause_req;
  assign ctl.load_use      = load_use;
  assign ctl.branch_taken  = branch_taken;
  assign ctl4.halt_req     = halt_req;
  assign ctl4.pause_req    = pause_req;
  assign ctl4.load_use     = load_use;
  assign ctl4.branch_taken = branch_taken;

  pipeline_sequencer dut (
    .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn), .ctl(ctl.master),
    .state(state), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn), .ctl(ctl4.master),
    .state(state4), .cycle_cnt(cycle4), .stall_cnt(stall4), .flush_cnt(flush4)
  );

  wire [4:0] en  = {ctl.pc_en, ctl.if_id_en, ctl.id_exe_en, ctl.exe_mem_en, ctl.mem_wb_en};
  wire [3:0] en4 = {ctl.pc_en, ctl.if_id_en, ctl.exe_mem_en, ctl.mem_wb_en};
  wire [1:0] clr = {ctl.if_id_clr, ctl.id_exe_clr};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run_btn = 1'b1; step_btn = 1'b0;
    halt_req = 1'b0; pause_req = 1'b0; load_use = 1'b0; branch_taken = 1'b0;
    cyc(); cyc();
    check_eq("rst_en", 32'(en), 32'h0);
    check_eq("rst_clr", 32'(clr), 32'h0);
    check_eq("rst_state", 32'(state), 32'h0);
    check_eq("rst_cycle", cycle_cnt, 32'h0);

    rst = 1'b0;
    cyc(); cyc();
    check_eq("held_btn_no_run", 32'(state), 32'h0);

    run_btn = 1'b0; cyc();
    run_btn = 1'b1; #1;
    check_eq("pre_run_state", 32'(state), 32'h0);
    cyc();
    check_eq("run_state", 32'(state), 32'h1);
    check_eq("run_en", 32'(en), 32'h1f);
    check_eq("run_clr", 32'(clr), 32'h0);
    repeat (5) cyc();
    check_eq("cycle5", cycle_cnt, 32'd5);

    load_use = 1'b1; #1;
    check_eq("lu1_en", 32'(en4), 32'h3);
    check_eq("lu1_clr", 32'(clr), 32'h1);
    cyc();
    check_eq("lu2_en", 32'(en4), 32'h3);
    check_eq("lu2_clr", 32'(clr), 32'h1);
    cyc();
    load_use = 1'b0;
    check_eq("stall2", stall_cnt, 32'd2);
    check_eq("cycle7", cycle_cnt, 32'd7);

    load_use = 1'b1; branch_taken = 1'b1; #1;
    check_eq("flush_en", 32'(en), 32'h1f);
    check_eq("flush_clr", 32'(clr), 32'h3);
    cyc();
    load_use = 1'b0; branch_taken = 1'b0;
    check_eq("flush1", flush_cnt, 32'd1);
    check_eq("stall_kept", stall_cnt, 32'd2);
    check_eq("cycle8", cycle_cnt, 32'd8);

    pause_req = 1'b1; #1;
    check_eq("pause_en_same", 32'(en), 32'h0);
    cyc();
    check_eq("paused_state", 32'(state), 32'h3);
    check_eq("paused_cycle", cycle_cnt, 32'd8);

    run_btn = 1'b0; cyc();
    run_btn = 1'b1; #1;
    check_eq("paused_wait", 32'(state), 32'h3);
    cyc();
    check_eq("resume_state", 32'(state), 32'h1);
    check_eq("resume_en", 32'(en), 32'h1f);
    cyc();
    check_eq("repause_state", 32'(state), 32'h1);
    check_eq("repause_en", 32'(en), 32'h0);
    check_eq("cycle9", cycle_cnt, 32'd9);
    cyc();
    check_eq("repaused", 32'(state), 32'h3);

    pause_req = 1'b0; step_btn = 1'b1; #1;
    check_eq("pre_step", 32'(state), 32'h3);
    cyc();
    check_eq("step_state", 32'(state), 32'h2);
    check_eq("step_en", 32'(en), 32'h1f);
    cyc();
    check_eq("after_step", 32'(state), 32'h3);
    check_eq("step_cycle", cycle_cnt, 32'd10);
    check_eq("after_step_en", 32'(en), 32'h0);

    run_btn = 1'b0; step_btn = 1'b0; cyc();
    run_btn = 1'b1; step_btn = 1'b1; cyc();
    check_eq("run_wins", 32'(state), 32'h1);

    halt_req = 1'b1; pause_req = 1'b1; #1;
    check_eq("halt_en", 32'(en), 32'h0);
    cyc();
    check_eq("halted", 32'(state), 32'h4);
    check_eq("halt_cycle", cycle_cnt, 32'd10);
    check_eq("halt_flush", flush_cnt, 32'd1);

    halt_req = 1'b0; pause_req = 1'b0; run_btn = 1'b0; step_btn = 1'b0; cyc();
    run_btn = 1'b1; step_btn = 1'b1; cyc(); cyc();
    check_eq("halt_sticky", 32'(state), 32'h4);
    check_eq("halt_sticky_en", 32'(en), 32'h0);

    rst = 1'b1; cyc();
    rst = 1'b0;
    check_eq("rst2_state", 32'(state), 32'h0);
    check_eq("rst2_cycle", cycle_cnt, 32'h0);
    check_eq("rst2_stall", stall_cnt, 32'h0);
    check_eq("rst2_flush", flush_cnt, 32'h0);

    run_btn = 1'b0; step_btn = 1'b0; cyc();
    step_btn = 1'b1; cyc();
    check_eq("step2_state", 32'(state), 32'h2);
    rst = 1'b1; #1;
    check_eq("rst_in_step_en", 32'(en), 32'h0);
    cyc();
    check_eq("rst_in_step_state", 32'(state), 32'h0);

    rst = 1'b0; step_btn = 1'b0; cyc();
    run_btn = 1'b1; cyc();
    check_eq("run3_state", 32'(state), 32'h1);
    repeat (20) cyc();
    check_eq("sat_cycle4", 32'(cycle4), 32'hf);
    check_eq("cycle20", cycle_cnt, 32'd20);
    cyc(); cyc();
    check_eq("sat_hold4", 32'(cycle4), 32'hf);
    check_eq("cycle22", cycle_cnt, 32'd22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter: CNT_W, default 32, width of the cycle, stall and flush counters.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk, input, 1, pipeline clock (post frequency_switch).
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Port: run_btn, input, 1, board run level; rising edge = run request.
REQ-006 Port: step_btn, input, 1, board step level; rising edge = single-step request.
REQ-007 Port: halt_req, input, 1, syscall with A=0xA present in WB.
REQ-008 Port: pause_req, input, 1, syscall with A=0x32 present in WB.
REQ-009 Port: load_use, input, 1, bubble request from the redirection unit.
REQ-010 Port: branch_taken, input, 1, EXE-stage npc differs from pc+4.
REQ-011 Port: pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, output, 1 each, register enables.
REQ-012 Port: if_id_clr, id_exe_clr, output, 1 each, synchronous clears of the IF/ID and ID/EXE registers.
REQ-013 Port: state, output, 3, encoded FSM state.
REQ-014 Port: cycle_cnt, stall_cnt, flush_cnt, output, CNT_W each, statistics counters.

Function
REQ-015 State encoding: IDLE=000, RUN=001, STEP=010, PAUSED=011, HALTED=100.
REQ-016 Button edges are detected from one registered copy of each button; the level must be low on the previous cycle and high on the current one.
REQ-017 IDLE: run edge goes to RUN; step edge goes to STEP.
REQ-018 PAUSED: run edge goes to RUN; step edge goes to STEP.
REQ-019 If the run edge and step edge occur in the same cycle, run wins.
REQ-020 RUN: halt_req goes to HALTED; otherwise pause_req goes to PAUSED.
REQ-021 STEP lasts exactly one cycle.
REQ-022 STEP: halt_req goes to HALTED; otherwise pause_req goes to PAUSED; otherwise the next state is PAUSED.
REQ-023 HALTED is terminal; only rst exits it.
REQ-024 If halt_req and pause_req are both asserted, halt wins.
REQ-025 pause_req is ignored in the first cycle of RUN or STEP entered from PAUSED, so that the frozen syscall can leave WB.
REQ-026 Active cycle: state is RUN or STEP, and halt_req=0, and pause_req is not currently honoured.
REQ-027 The active-cycle decision is combinational, so enables drop in the same cycle that a halt or pause is honoured.
REQ-028 Active cycle with no hazard: all five enables = 1; both clears = 0.
REQ-029 Active cycle with load_use=1 and branch_taken=0: pc_en=0 and if_id_en=0; id_exe_clr=1; exe_mem_en=1 and mem_wb_en=1.
REQ-030 Active cycle with branch_taken=1: if_id_clr=1, id_exe_clr=1, and all enables = 1, whatever the value of load_use.
REQ-031 Inactive cycle: all enables = 0 and both clears = 0.
REQ-032 cycle_cnt increments by 1 every active cycle.
REQ-033 stall_cnt increments by 1 every active cycle that uses the REQ-029 case.
REQ-034 flush_cnt increments by 1 every active cycle that uses the REQ-030 case.
REQ-035 All counters saturate at all-ones and never wrap.
REQ-036 Counters hold their values in PAUSED and HALTED.

Reset
REQ-037 On rst=1 at a clock edge: state=IDLE, all counters=0, button edge registers=0.
REQ-038 Reset overrides every other input and every state, including a STEP in progress.
REQ-039 While rst=1, all enables = 0 and both clears = 0.
REQ-040 After rst is released, no run edge is detected from a button that was already held high during reset.

Verification
REQ-041 Reset, then run_btn rises at cycle 2 -> state=001 at cycle 3; all enables = 1; cycle_cnt=5 after 5 active cycles.
REQ-042 RUN with load_use=1 for 2 cycles -> pc_en=0 and if_id_en=0 for those 2 cycles, id_exe_clr=1, stall_cnt=2; with load_use and branch_taken both 1 -> flush case applies and flush_cnt increments.
REQ-043 RUN with pause_req=1 -> enables=0 in the same cycle, state=011 next cycle; run edge with pause_req still high -> one active cycle, pause_req then honoured again only if still asserted on the second cycle.
REQ-044 PAUSED, step edge -> exactly one cycle with enables=1 (state=010), then state=011; cycle_cnt +1.
REQ-045 RUN with halt_req=1 and pause_req=1 -> state=100; run and step edges then ignored; rst -> state=000 and all counters=0.
REQ-046 CNT_W=4, run 20 active cycles -> cycle_cnt=0xF, held at 0xF.
